accel_result_sink: RTL and testbench
====================================

Name: accel_result_sink

Overview:
- Downstream stage of the conv1d accelerator. Snoops the accelerator's result write beats (accel_mem_req & accel_mem_we) on the shared memory bus.
- Requantizes each 32-bit result to signed 8-bit: arithmetic shift, optional ReLU, saturation.
- Buffers results in a small FIFO and presents them as a valid/ready stream with index and last markers.
- Tracks per-frame beat count, saturation count, overflow and count-mismatch errors.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2)
- N_OUT, 128, result beats expected per frame
- OUT_W, 8, width of requantized output (signed)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- accel_running  in  1  accelerator running level
- accel_done  in  1  accelerator done pulse (1 cycle)
- accel_mem_req  in  1  accelerator memory request
- accel_mem_we  in  1  accelerator write enable
- accel_result  in  32  accelerator write data, signed
- shift_amt  in  5  right-shift amount, sampled at frame start
- relu_en  in  1  clamp negatives to 0, sampled at frame start
- out_valid  out  1  stream data valid
- out_ready  in  1  stream consumer ready
- out_data  out  OUT_W  requantized result
- out_idx  out  7  beat ordinal within frame, 0..N_OUT-1
- out_last  out  1  high with the beat whose out_idx == N_OUT-1
- busy  out  1  state != IDLE
- frame_done  out  1  1-cycle pulse when the frame is fully drained
- ovf_err  out  1  sticky: a beat was dropped on a full FIFO
- cnt_err  out  1  sticky: beat count != N_OUT at accel_done
- sat_cnt  out  8  saturated beats this frame, saturates at 255

Behaviour:
- Reset (rst=1 at an edge): state IDLE, FIFO empty, all outputs 0. This includes out_data and out_idx, and holds even if reset arrives mid-frame. A pending frame is abandoned.
- Write beat = accel_mem_req & accel_mem_we sampled at a rising edge.
- State machine:
  - IDLE -> CAPTURE when accel_running=1. On that edge: latch shift_amt and relu_en; clear beat counter, sat_cnt, ovf_err and cnt_err.
  - CAPTURE: every write beat is pushed. On accel_done=1 -> DRAIN. A beat in the same cycle as accel_done is still captured. cnt_err is set if the final count (including that beat) != N_OUT.
  - DRAIN: no captures. -> DONE when the FIFO is empty.
  - DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- Beats outside CAPTURE are ignored. A new accel_running in DRAIN or DONE waits until IDLE.
- Requantization, combinational at push:
  - s = accel_result >>> shift_amt (arithmetic).
  - If relu_en and s<0, then s=0.
  - If s>127, out=127; if s<-128, out=-128; else out=s[7:0].
  - sat_cnt increments only when a clamp to 127/-128 occurs. The ReLU clamp does not count.
- Index: each pushed entry stores the beat ordinal mod N_OUT alongside its data, and out_last = (stored idx == N_OUT-1). More than N_OUT beats wraps the index to 0; cnt_err is raised at done.
- FIFO and stream:
  - Registered FIFO. A beat pushed at edge k into an empty FIFO gives out_valid=1 in the cycle after edge k (1-cycle latency).
  - Pop when out_valid & out_ready.
  - out_data, out_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - Full FIFO with a simultaneous pop: the push succeeds and occupancy is unchanged.
  - Full FIFO with no pop: the beat is dropped, ovf_err is set, and the beat counter still increments, so the dropped beat's index is skipped.
  - Empty FIFO with a simultaneous push and pop is not possible, since out_valid=0 when empty.
- The accelerator has no stall input. The consumer must sustain 1 beat per 2 cycles on average, matching the accelerator's write rate; DEPTH absorbs bursts.

Test Plan:
- Nominal frame:
  - Stimulus: shift=8, relu=0; 128 beats of result=i<<8 (i=0..127) with out_ready=1.
  - Response: out_data=i, out_idx=i; out_last only at idx 127; frame_done once after the last pop; sat_cnt=0, errors 0.
- Saturation/ReLU:
  - Stimulus: shift=0; results 300, -300, -5, 127 with relu=0, then the same frame with relu=1.
  - Response (relu=0): outputs 127, -128, -5, 127; sat_cnt=2.
  - Response (relu=1): outputs 127, 0, 0, 127; sat_cnt=1.
- Backpressure/overflow:
  - Stimulus: out_ready=0 for the whole frame.
  - Response: the first 8 beats are held with index 0..7; ovf_err=1; after out_ready=1 exactly 8 beats drain, then frame_done.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 on the same edge as a beat.
  - Response: the beat is accepted, ovf_err stays 0, and occupancy stays 8.
- Count error:
  - Stimulus: accel_done after 127 beats; a separate run with 129 beats.
  - Response: cnt_err=1 in both. In the 129 case the last beat has out_idx=0.
- Reset mid-frame:
  - Stimulus: rst=1 after 40 beats with data in the FIFO.
  - Response: next cycle out_valid=0, busy=0, all flags 0; a following frame runs normally from idx 0.

Source files
------------

// File: rtl/accel_result_sink_if.sv
// Result stream from accel_result_sink to its consumer: valid/ready handshake
// carrying the requantized value, its beat ordinal and an end-of-frame marker.
interface accel_result_sink_if #(
  parameter int OUT_W = 8
) ();
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [6:0]       out_idx;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/accel_result_sink.sv
// Snoops conv1d accelerator result writes, requantizes them to OUT_W-bit signed,
// buffers them in a small FIFO and streams them out with per-frame bookkeeping.
module accel_result_sink #(
  parameter int DEPTH = 8,
  parameter int N_OUT = 128,
  parameter int OUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       accel_running,
  input  logic                       accel_done,
  input  logic                       accel_mem_req,
  input  logic                       accel_mem_we,
  input  logic [31:0]                accel_result,
  input  logic [4:0]                 shift_amt,
  input  logic                       relu_en,
  accel_result_sink_if.master        stream,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       ovf_err,
  output logic                       cnt_err,
  output logic [7:0]                 sat_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int IW    = 7;
  localparam int ENT_W = OUT_W + IW;
  localparam logic [AW-1:0]        PTR_ONE = AW'(1'b1);
  localparam logic signed [31:0]   SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0]   SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Returns {saturated, value}; the ReLU clamp is not reported as saturation.
  function automatic logic [OUT_W:0] requant(input logic [31:0] res,
                                              input logic [4:0]  sh,
                                              input logic        relu);
    logic signed [31:0] s;
    logic               sat;
    s   = $signed(res) >>> sh;
    sat = 1'b0;
    if (relu && (s < 32'sd0)) begin
      s = 32'sd0;
    end else begin
      s = s;
    end
    if (s > SAT_MAX) begin
      s   = SAT_MAX;
      sat = 1'b1;
    end else if (s < SAT_MIN) begin
      s   = SAT_MIN;
      sat = 1'b1;
    end else begin
      sat = 1'b0;
    end
    return {sat, s[OUT_W-1:0]};
  endfunction

  state_t            state_r;
  logic [4:0]        shift_r;
  logic              relu_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     fifo_cnt_r;
  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [IW-1:0]     idx_r;
  logic [15:0]       beat_cnt_r;

  logic              beat_s;
  logic              pop_s;
  logic              full_s;
  logic              push_s;
  logic              drop_s;
  logic [OUT_W:0]    rq_s;
  logic [ENT_W-1:0]  push_ent_s;
  logic [AW-1:0]     rd_next_s;
  logic [CW-1:0]     remain_s;
  logic [CW-1:0]     fifo_cnt_next_s;
  logic              head_load_s;
  logic [ENT_W-1:0]  head_next_s;
  logic [15:0]       beat_cnt_inc_s;
  logic [IW-1:0]     idx_inc_s;
  logic [7:0]        sat_cnt_inc_s;

  // FIFO control, requantization and the next head entry for the output registers.
  always_comb begin
    beat_s     = accel_mem_req & accel_mem_we & (state_r == CAPTURE);
    pop_s      = stream.out_valid & stream.out_ready;
    full_s     = (fifo_cnt_r == CW'(DEPTH));
    push_s     = beat_s & (~full_s | pop_s);
    drop_s     = beat_s & full_s & ~pop_s;
    rq_s       = requant(accel_result, shift_r, relu_r);
    push_ent_s = {idx_r, rq_s[OUT_W-1:0]};
    rd_next_s  = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    remain_s   = fifo_cnt_r - {{(CW-1){1'b0}}, pop_s};
    fifo_cnt_next_s = remain_s + {{(CW-1){1'b0}}, push_s};

    // The slot at rd_next is never the write slot while entries remain, so old contents are valid.
    if (remain_s != {CW{1'b0}}) begin
      head_load_s = 1'b1;
      head_next_s = mem_r[rd_next_s];
    end else if (push_s) begin
      head_load_s = 1'b1;
      head_next_s = push_ent_s;
    end else begin
      head_load_s = 1'b0;
      head_next_s = {ENT_W{1'b0}};
    end

    if (beat_s && (beat_cnt_r != 16'hFFFF)) begin
      beat_cnt_inc_s = beat_cnt_r + 16'd1;
    end else begin
      beat_cnt_inc_s = beat_cnt_r;
    end

    if (idx_r == IW'(N_OUT - 1)) begin
      idx_inc_s = {IW{1'b0}};
    end else begin
      idx_inc_s = idx_r + 7'd1;
    end

    if (beat_s && rq_s[OUT_W] && (sat_cnt != 8'hFF)) begin
      sat_cnt_inc_s = sat_cnt + 8'd1;
    end else begin
      sat_cnt_inc_s = sat_cnt;
    end
  end

  // Frame state machine, FIFO storage and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      shift_r          <= 5'd0;
      relu_r           <= 1'b0;
      wr_ptr_r         <= {AW{1'b0}};
      rd_ptr_r         <= {AW{1'b0}};
      fifo_cnt_r       <= {CW{1'b0}};
      idx_r            <= {IW{1'b0}};
      beat_cnt_r       <= 16'd0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= {OUT_W{1'b0}};
      stream.out_idx   <= 7'd0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      ovf_err          <= 1'b0;
      cnt_err          <= 1'b0;
      sat_cnt          <= 8'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_ent_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r         <= rd_next_s;
      fifo_cnt_r       <= fifo_cnt_next_s;
      stream.out_valid <= (fifo_cnt_next_s != {CW{1'b0}});
      if (head_load_s) begin
        stream.out_data <= head_next_s[OUT_W-1:0];
        stream.out_idx  <= head_next_s[ENT_W-1:OUT_W];
        stream.out_last <= (head_next_s[ENT_W-1:OUT_W] == IW'(N_OUT - 1));
      end
      frame_done <= 1'b0;

      case (state_r)
        IDLE: begin
          if (accel_running) begin
            state_r    <= CAPTURE;
            shift_r    <= shift_amt;
            relu_r     <= relu_en;
            idx_r      <= {IW{1'b0}};
            beat_cnt_r <= 16'd0;
            sat_cnt    <= 8'd0;
            ovf_err    <= 1'b0;
            cnt_err    <= 1'b0;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        CAPTURE: begin
          // Dropped beats still advance the ordinal, leaving a gap in out_idx.
          if (beat_s) begin
            idx_r <= idx_inc_s;
          end
          beat_cnt_r <= beat_cnt_inc_s;
          sat_cnt    <= sat_cnt_inc_s;
          if (drop_s) begin
            ovf_err <= 1'b1;
          end
          if (accel_done) begin
            state_r <= DRAIN;
            if (beat_cnt_inc_s != 16'(N_OUT)) begin
              cnt_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_cnt_r == {CW{1'b0}}) begin
            state_r    <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_result_sink.sv
// Directed bench for accel_result_sink: nominal frame, saturation/ReLU,
// backpressure and overflow, full-with-pop, count errors and mid-frame reset.
module tb_accel_result_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        accel_running;
  logic        accel_done;
  logic        accel_mem_req;
  logic        accel_mem_we;
  logic [31:0] accel_result;
  logic [4:0]  shift_amt;
  logic        relu_en;
  logic        busy;
  logic        frame_done;
  logic        ovf_err;
  logic        cnt_err;
  logic [7:0]  sat_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;

  logic [7:0] q_data[$];
  logic [6:0] q_idx[$];
  logic       q_last[$];

  accel_result_sink_if #(.OUT_W(8)) sif ();

  accel_result_sink #(.DEPTH(8), .N_OUT(128), .OUT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .accel_running (accel_running),
    .accel_done    (accel_done),
    .accel_mem_req (accel_mem_req),
    .accel_mem_we  (accel_mem_we),
    .accel_result  (accel_result),
    .shift_amt     (shift_amt),
    .relu_en       (relu_en),
    .stream        (sif),
    .busy          (busy),
    .frame_done    (frame_done),
    .ovf_err       (ovf_err),
    .cnt_err       (cnt_err),
    .sat_cnt       (sat_cnt)
  );

  always #5 clk = ~clk;

  // Record every handshake and frame_done pulse mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (!rst && sif.out_valid && sif.out_ready) begin
      q_data.push_back(sif.out_data);
      q_idx.push_back(sif.out_idx);
      q_last.push_back(sif.out_last);
    end
    if (!rst && frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_idx.delete();
    q_last.delete();
  endtask

  task automatic start_frame(input logic [4:0] sh, input logic relu);
    shift_amt     = sh;
    relu_en       = relu;
    accel_running = 1'b1;
    tick();
  endtask

  // One write beat followed by an idle cycle; optionally with accel_done on the beat.
  task automatic beat(input logic [31:0] d, input logic with_done);
    accel_mem_req = 1'b1;
    accel_mem_we  = 1'b1;
    accel_result  = d;
    accel_done    = with_done;
    if (with_done) accel_running = 1'b0;
    tick();
    accel_mem_req = 1'b0;
    accel_mem_we  = 1'b0;
    accel_done    = 1'b0;
    tick();
  endtask

  task automatic finish_frame();
    accel_done    = 1'b1;
    accel_running = 1'b0;
    tick();
    accel_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int  fd0;
    bit  seen;
    fd0  = fd_cnt;
    seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (fd_cnt != fd0) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int fd0;
    logic [7:0] sat_exp [4];
    rst = 1'b1;
    accel_running = 1'b0;
    accel_done = 1'b0;
    accel_mem_req = 1'b0;
    accel_mem_we = 1'b0;
    accel_result = 32'd0;
    shift_amt = 5'd0;
    relu_en = 1'b0;
    sif.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(sif.out_data), 32'd0);
    check("rst_idx", 32'(sif.out_idx), 32'd0);
    check("rst_flags", {29'd0, frame_done, ovf_err, cnt_err}, 32'd0);
    check("rst_sat", 32'(sat_cnt), 32'd0);

    // Nominal frame; the last beat coincides with accel_done.
    clear_q();
    fd0 = fd_cnt;
    sif.out_ready = 1'b1;
    start_frame(5'd8, 1'b0);
    check("nom_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 128; i++) beat(32'(i) << 8, (i == 127));
    wait_done("nom_done_timeout");
    check("nom_count", 32'(q_data.size()), 32'd128);
    for (int i = 0; i < 128 && i < q_data.size(); i++) begin
      check($sformatf("nom_data%0d", i), 32'(q_data[i]), 32'(i));
      check($sformatf("nom_idx%0d", i), 32'(q_idx[i]), 32'(i));
      check($sformatf("nom_last%0d", i), 32'(q_last[i]), 32'(i == 127));
    end
    check("nom_fd_once", 32'(fd_cnt - fd0), 32'd1);
    check("nom_sat", 32'(sat_cnt), 32'd0);
    check("nom_ovf", 32'(ovf_err), 32'd0);
    check("nom_cnt", 32'(cnt_err), 32'd0);
    check("nom_busy_end", 32'(busy), 32'd0);

    // Saturation without and with ReLU.
    for (int r = 0; r < 2; r++) begin
      clear_q();
      start_frame(5'd0, r[0]);
      beat(32'd300, 1'b0);
      beat(-32'sd300, 1'b0);
      beat(-32'sd5, 1'b0);
      beat(32'd127, 1'b1);
      wait_done("sat_done_timeout");
      if (r == 0) sat_exp = '{8'h7F, 8'h80, 8'hFB, 8'h7F};
      else        sat_exp = '{8'h7F, 8'h00, 8'h00, 8'h7F};
      check("sat_count", 32'(q_data.size()), 32'd4);
      for (int i = 0; i < 4 && i < q_data.size(); i++)
        check($sformatf("sat_r%0d_data%0d", r, i), 32'(q_data[i]), 32'(sat_exp[i]));
      check($sformatf("sat_r%0d_cnt", r), 32'(sat_cnt), (r == 0) ? 32'd2 : 32'd1);
      check("sat_cnt_err", 32'(cnt_err), 32'd1);
    end

    // Backpressure for the whole frame: 8 held, rest dropped.
    clear_q();
    sif.out_ready = 1'b0;
    start_frame(5'd0, 1'b0);
    check("bp_empty_valid", 32'(sif.out_valid), 32'd0);
    accel_mem_req = 1'b1;
    accel_mem_we = 1'b1;
    accel_result = 32'd0;
    tick();
    check("bp_latency_valid", 32'(sif.out_valid), 32'd1);
    check("bp_latency_idx", 32'(sif.out_idx), 32'd0);
    accel_mem_req = 1'b0;
    accel_mem_we = 1'b0;
    tick();
    for (int i = 1; i < 20; i++) beat(32'(i + 50), 1'b0);
    check("bp_ovf", 32'(ovf_err), 32'd1);
    check("bp_hold_data", 32'(sif.out_data), 32'd0);
    check("bp_hold_idx", 32'(sif.out_idx), 32'd0);
    finish_frame();
    tick();
    tick();
    check("bp_drain_busy", 32'(busy), 32'd1);
    sif.out_ready = 1'b1;
    wait_done("bp_done_timeout");
    check("bp_count", 32'(q_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < q_idx.size(); i++) begin
      check($sformatf("bp_idx%0d", i), 32'(q_idx[i]), 32'(i));
      check($sformatf("bp_data%0d", i), 32'(q_data[i]), (i == 0) ? 32'd0 : 32'(i + 50));
    end

    // Full FIFO with a pop on the same edge as a beat.
    clear_q();
    sif.out_ready = 1'b0;
    start_frame(5'd0, 1'b0);
    for (int i = 0; i < 8; i++) beat(32'(i), 1'b0);
    accel_mem_req = 1'b1;
    accel_mem_we = 1'b1;
    accel_result = 32'd8;
    sif.out_ready = 1'b1;
    tick();
    check("full_pop_ovf", 32'(ovf_err), 32'd0);
    check("full_pop_head_idx", 32'(sif.out_idx), 32'd1);
    accel_mem_req = 1'b0;
    accel_mem_we = 1'b0;
    sif.out_ready = 1'b0;
    tick();
    finish_frame();
    sif.out_ready = 1'b1;
    wait_done("full_done_timeout");
    check("full_total", 32'(q_data.size()), 32'd9);
    if (q_data.size() == 9) begin
      check("full_last_idx", 32'(q_idx[8]), 32'd8);
      check("full_last_data", 32'(q_data[8]), 32'd8);
    end
    check("full_ovf_end", 32'(ovf_err), 32'd0);

    // Count error: 127 beats.
    clear_q();
    start_frame(5'd0, 1'b0);
    for (int i = 0; i < 127; i++) beat(32'(i % 100), (i == 126));
    wait_done("c127_done_timeout");
    check("c127_cnt_err", 32'(cnt_err), 32'd1);
    check("c127_count", 32'(q_idx.size()), 32'd127);
    if (q_idx.size() == 127) check("c127_last_idx", 32'(q_idx[126]), 32'd126);

    // Count error: 129 beats, index wraps.
    clear_q();
    start_frame(5'd0, 1'b0);
    for (int i = 0; i < 129; i++) beat(32'(i % 100), (i == 128));
    wait_done("c129_done_timeout");
    check("c129_cnt_err", 32'(cnt_err), 32'd1);
    check("c129_count", 32'(q_idx.size()), 32'd129);
    if (q_idx.size() == 129) begin
      check("c129_idx127_last", 32'(q_last[127]), 32'd1);
      check("c129_wrap_idx", 32'(q_idx[128]), 32'd0);
      check("c129_wrap_last", 32'(q_last[128]), 32'd0);
      check("c129_wrap_data", 32'(q_data[128]), 32'd28);
    end

    // Reset mid-frame with data held in the FIFO.
    clear_q();
    sif.out_ready = 1'b1;
    start_frame(5'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i == 30) sif.out_ready = 1'b0;
      beat(32'(100 + i), 1'b0);
    end
    check("mid_pre_valid", 32'(sif.out_valid), 32'd1);
    check("mid_pre_idx", 32'(sif.out_idx), 32'd30);
    accel_running = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid", 32'(sif.out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_flags", {29'd0, frame_done, ovf_err, cnt_err}, 32'd0);
    check("mid_sat", 32'(sat_cnt), 32'd0);
    check("mid_data", 32'(sif.out_data), 32'd0);
    check("mid_idx", 32'(sif.out_idx), 32'd0);
    tick();
    clear_q();
    sif.out_ready = 1'b1;
    start_frame(5'd0, 1'b0);
    for (int i = 0; i < 4; i++) beat(32'(5 + i), (i == 3));
    wait_done("post_done_timeout");
    check("post_count", 32'(q_idx.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_idx.size(); i++) begin
      check($sformatf("post_idx%0d", i), 32'(q_idx[i]), 32'(i));
      check($sformatf("post_data%0d", i), 32'(q_data[i]), 32'(5 + i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
